serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 11 +
 rtl/serial_adder_half_adder.sv | 13 +
 rtl/serial_adder.sv | 121 ++++++++++++
 tb/tb_serial_adder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: FSM state encodings
// and the default operand width.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

endpackage

// File: rtl/serial_adder_half_adder.sv
// One-bit half adder; two of these plus an OR form the serial
// adder's full-adder cell.
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one operand bit per clock, LSB first, result
// registered on the cycle the MSB is processed.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             cy_q, cy_d;
    logic             carry_q, carry_d;

    logic ha0_s, ha0_c;
    logic fa_s, ha1_c;
    logic fa_c;

    half_adder u_ha0 (
        .a     (opa_q[0]),
        .b     (opb_q[0]),
        .sum   (ha0_s),
        .carry (ha0_c)
    );

    half_adder u_ha1 (
        .a     (ha0_s),
        .b     (cy_q),
        .sum   (fa_s),
        .carry (ha1_c)
    );

    assign fa_c = ha0_c | ha1_c;

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        cy_d    = cy_q;
        carry_d = carry_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    opa_d   = a;
                    opb_d   = b;
                    res_d   = '0;
                    cnt_d   = '0;
                    cy_d    = 1'b0;
                end
            end
            SHIFT: begin
                res_d = {fa_s, res_q[WIDTH-1:1]};
                cy_d  = fa_c;
                opa_d = opa_q >> 1;
                opb_d = opb_q >> 1;
                cnt_d = cnt_q + CW'(1);
                // Counter parks at zero rather than wrapping past LAST
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    sum_d   = {fa_s, res_q[WIDTH-1:1]};
                    carry_d = fa_c;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            cy_q    <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            cy_q    <= cy_d;
            carry_q <= carry_d;
        end
    end

    assign busy  = (state_q == SHIFT) || (state_q == DONE);
    assign done  = (state_q == DONE);
    assign sum   = sum_q;
    assign carry = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: directed corner cases plus
// random back-to-back additions against a plain-arithmetic model.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        int           acc;
    } exp_t;

    exp_t q[$];
    int   errors;
    int   checks;
    int   cyc;
    int   npush;
    int   ndone;
    int   run;
    logic [W-1:0] last_sum;
    logic         last_carry;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .carry (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x,
                                   input logic [W-1:0] y, input int acc);
        exp_t e;
        int   t;
        t     = int'(x) + int'(y);
        e.s   = W'(t % (1 << W));
        e.c   = (t >= (1 << W));
        e.acc = acc;
        return e;
    endfunction

    // Monitor: pops the scoreboard on every done pulse
    always @(negedge clk) begin
        if (rst) begin
            run        = 0;
            last_sum   = '0;
            last_carry = 1'b0;
        end else begin
            if (busy) begin
                run++;
            end else if (run != 0) begin
                chk("busy_len", run, W + 1);
                run = 0;
            end
            if (done) begin
                ndone++;
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("sum", sum, e.s);
                    chk("carry", carry, e.c);
                    chk("latency", cyc - e.acc, W);
                    last_sum   = e.s;
                    last_carry = e.c;
                end
            end else begin
                chk("hold_sum", sum, last_sum);
                chk("hold_carry", carry, last_carry);
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 1, 0);
    endtask

    task automatic do_add(input logic [W-1:0] x, input logic [W-1:0] y);
        wait_idle();
        start = 1'b1;
        a     = x;
        b     = y;
        q.push_back(model(x, y, cyc + 1));
        npush++;
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        cyc    = 0;
        npush  = 0;
        ndone  = 0;
        run    = 0;
        last_sum   = '0;
        last_carry = 1'b0;
        rst   = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_carry", carry, 0);
        rst = 1'b0;

        do_add(8'h00, 8'h00);
        do_add(8'h5A, 8'hA5);
        do_add(8'hFF, 8'h01);
        do_add(8'hFF, 8'hFF);

        // Second start mid-operation must be dropped
        do_add(8'h03, 8'h04);
        repeat (3) @(negedge clk);
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'hFF;
        @(negedge clk);
        start = 1'b0;

        // Abort mid-operation, then start held through reset
        do_add(8'hFF, 8'h01);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_sum", sum, 0);
        chk("abort_carry", carry, 0);
        void'(q.pop_back());
        npush--;
        start = 1'b1;
        a     = 8'h10;
        b     = 8'h20;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        q.push_back(model(8'h10, 8'h20, cyc + 1));
        npush++;
        @(negedge clk);
        start = 1'b0;

        for (int i = 0; i < 40; i++) begin
            do_add(W'($urandom), W'($urandom));
        end

        begin
            int n;
            n = 0;
            while (q.size() != 0 && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        chk("drain", q.size(), 0);
        repeat (3) @(negedge clk);
        chk("done_count", ndone, npush);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
